// File: rtl/audio_sample_scheduler_if.sv
// HPS PIO and codec serializer signals of the left-channel audio scheduler.
// slave is the scheduler side; master is the HPS/codec side driving it.
interface audio_sample_scheduler_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        ctrl;
  logic [DATA_W-1:0] dac_data;
  logic [DATA_W-1:0] adc_data;
  logic [15:0]       space;
  logic [2:0]        status;
  logic              sample_tick;
  logic [DATA_W-1:0] dac_sample;
  logic              dac_valid;
  logic              dac_ready;
  logic [DATA_W-1:0] adc_sample;
  logic              adc_valid;

  modport master (
    output ctrl, dac_data, sample_tick, dac_ready, adc_sample, adc_valid,
    input  adc_data, space, status, dac_sample, dac_valid
  );

  modport slave (
    input  ctrl, dac_data, sample_tick, dac_ready, adc_sample, adc_valid,
    output adc_data, space, status, dac_sample, dac_valid
  );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Left-channel play/record sample scheduler: tick -> dac_valid 1 cycle, toggle pop -> adc_data 1 cycle.
// Play output holds dac_sample until dac_ready; ticks arriving while a sample is pending are dropped as late.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic              push_ok,
  output logic              pop_ok,
  output logic [ADDR_W:0]   count
);
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              empty;
  logic              full;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees a slot for a same-cycle push; a push into an empty FIFO
  // passes straight through to a same-cycle pop.
  assign push_ok  = !clr && push && (!full || pop);
  assign pop_ok   = !clr && pop && (!empty || push);
  assign head_dat = empty ? push_dat : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module audio_sample_scheduler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  audio_sample_scheduler_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state, state_d;
  logic              wr_prev, rd_prev, hist_vld;
  logic              wr_evt, rd_evt;
  logic              enable, clr;
  logic              ctrl_unused;

  logic              play_pop, play_load, late_evt;
  logic              play_push_ok, play_pop_ok;
  logic [DATA_W-1:0] play_head;
  logic [CNT_W-1:0]  play_count, play_free;

  logic              rec_push;
  logic              rec_push_ok, rec_pop_ok;
  logic [DATA_W-1:0] rec_head;
  logic [CNT_W-1:0]  rec_count;

  logic              underrun_evt, overrun_evt;
  logic [DATA_W-1:0] dac_sample_q, adc_data_q;
  logic [2:0]        status_q;

  assign enable      = bus.ctrl[2];
  assign clr         = bus.ctrl[3];
  assign ctrl_unused = ^bus.ctrl[7:4];

  // History regs are unqualified until the first clock after reset so a
  // toggle bit left high by software does not fake an event.
  assign wr_evt = hist_vld && (bus.ctrl[0] ^ wr_prev);
  assign rd_evt = hist_vld && (bus.ctrl[1] ^ rd_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev  <= 1'b0;
      rd_prev  <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      wr_prev  <= bus.ctrl[0];
      rd_prev  <= bus.ctrl[1];
      hist_vld <= 1'b1;
    end
  end

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_play_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .push     (wr_evt),
    .push_dat (bus.dac_data),
    .pop      (play_pop),
    .head_dat (play_head),
    .push_ok  (play_push_ok),
    .pop_ok   (play_pop_ok),
    .count    (play_count)
  );

  assign rec_push = bus.adc_valid && enable;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_rec_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .push     (rec_push),
    .push_dat (bus.adc_sample),
    .pop      (rd_evt),
    .head_dat (rec_head),
    .push_ok  (rec_push_ok),
    .pop_ok   (rec_pop_ok),
    .count    (rec_count)
  );

  always_comb begin
    state_d   = state;
    play_pop  = 1'b0;
    play_load = 1'b0;
    late_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_tick && enable) begin
          play_pop  = 1'b1;
          play_load = 1'b1;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.dac_ready) state_d = IDLE;
        if (bus.sample_tick && enable) late_evt = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  assign underrun_evt = play_load && !play_pop_ok;
  assign overrun_evt  = (wr_evt && !play_push_ok) || (rec_push && !rec_push_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dac_sample_q <= '0;
      adc_data_q   <= '0;
      status_q     <= '0;
    end else begin
      state <= state_d;
      if (play_load && !clr) dac_sample_q <= play_pop_ok ? play_head : '0;
      if (rec_pop_ok)        adc_data_q   <= rec_head;
      if (clr) status_q <= '0;
      else     status_q <= status_q | {late_evt, overrun_evt, underrun_evt};
    end
  end

  assign play_free      = CNT_W'(FIFO_DEPTH) - play_count;
  assign bus.space      = {8'(rec_count), 8'(play_free)};
  assign bus.status     = status_q;
  assign bus.dac_sample = dac_sample_q;
  assign bus.dac_valid  = (state == PRESENT);
  assign bus.adc_data   = adc_data_q;
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: expected play/record samples are
// queued as stimulus is driven and checked when the DUT hands them out.
module tb_audio_sample_scheduler;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_dac[$];
  logic [31:0] exp_adc[$];

  audio_sample_scheduler_if #(.DATA_W(32)) aif ();

  audio_sample_scheduler #(.DATA_W(32), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (aif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_push(input logic [31:0] d);
    aif.dac_data = d;
    aif.ctrl[0]  = ~aif.ctrl[0];
    cyc();
  endtask

  task automatic pulse_tick();
    aif.sample_tick = 1'b1;
    cyc();
    aif.sample_tick = 1'b0;
  endtask

  task automatic adc_strobe(input logic [31:0] d);
    aif.adc_sample = d;
    aif.adc_valid  = 1'b1;
    cyc();
    aif.adc_valid  = 1'b0;
  endtask

  task automatic rd_pop();
    aif.ctrl[1] = ~aif.ctrl[1];
    cyc();
  endtask

  task automatic do_clear();
    aif.ctrl[3] = 1'b1;
    cyc();
    aif.ctrl[3] = 1'b0;
  endtask

  // Every completed play handshake must match the oldest expected sample.
  always @(negedge clk) begin
    if (reset_n && aif.dac_valid && aif.dac_ready) begin
      if (exp_dac.size() == 0) chk("dac_unexpected", aif.dac_sample, 32'hDEAD_BEEF);
      else                     chk("dac_sample", aif.dac_sample, exp_dac.pop_front());
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    aif.ctrl        = 8'h00;
    aif.dac_data    = '0;
    aif.sample_tick = 1'b0;
    aif.dac_ready   = 1'b1;
    aif.adc_sample  = '0;
    aif.adc_valid   = 1'b0;
    repeat (3) cyc();
    chk("rst_space", aif.space, 32'h0010);
    chk("rst_status", aif.status, 32'h0);
    chk("rst_dac_valid", aif.dac_valid, 32'h0);
    reset_n = 1'b1;
    repeat (2) cyc();

    // 1: three pushes, then three ticks drain them in order
    for (int i = 1; i <= 3; i++) begin
      wr_push(32'hA0 + i);
      exp_dac.push_back(32'hA0 + i);
    end
    aif.ctrl[2] = 1'b1;
    cyc();
    chk("t1_space_play", aif.space[7:0], 32'd13);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      chk("t1_dac_valid", aif.dac_valid, 32'h1);
      cyc();
    end
    chk("t1_drained", exp_dac.size(), 32'd0);

    // 2: tick on an empty play FIFO presents a zero sample and flags underrun
    exp_dac.push_back(32'h0);
    pulse_tick();
    chk("t2_dac_valid", aif.dac_valid, 32'h1);
    chk("t2_dac_sample", aif.dac_sample, 32'h0);
    chk("t2_status", aif.status, 32'h1);
    cyc();

    // 3: second tick while the first sample is still pending is late
    do_clear();
    aif.dac_ready = 1'b0;
    wr_push(32'hB1);
    wr_push(32'hB2);
    exp_dac.push_back(32'hB1);
    pulse_tick();
    cyc();
    pulse_tick();
    chk("t3_status", aif.status, 32'h4);
    chk("t3_dac_sample", aif.dac_sample, 32'hB1);
    chk("t3_space_play", aif.space[7:0], 32'd15);
    aif.dac_ready = 1'b1;
    repeat (2) cyc();
    chk("t3_dac_idle", aif.dac_valid, 32'h0);

    // 4: record FIFO overrun, then drain in order
    do_clear();
    for (int i = 0; i < 17; i++) begin
      adc_strobe(32'h100 + i);
      if (i < 16) exp_adc.push_back(32'h100 + i);
    end
    chk("t4_space_rec", aif.space[15:8], 32'd16);
    chk("t4_status", aif.status, 32'h2);
    for (int i = 0; i < 16; i++) begin
      rd_pop();
      chk("adc_data", aif.adc_data, exp_adc.pop_front());
    end
    chk("t4_space_rec_empty", aif.space[15:8], 32'd0);
    rd_pop();
    chk("t4_adc_hold", aif.adc_data, 32'h10F);
    aif.adc_valid = 1'b0;
    aif.ctrl[2] = 1'b0;
    adc_strobe(32'h55);
    chk("t4_rec_disabled", aif.space[15:8], 32'd0);
    aif.ctrl[2] = 1'b1;

    // 5: full play FIFO, push and tick-pop in the same cycle
    do_clear();
    for (int i = 0; i < 16; i++) begin
      wr_push(32'hC0 + i);
      exp_dac.push_back(32'hC0 + i);
    end
    chk("t5_space_full", aif.space[7:0], 32'd0);
    aif.dac_data    = 32'hD0;
    aif.ctrl[0]     = ~aif.ctrl[0];
    aif.sample_tick = 1'b1;
    cyc();
    aif.sample_tick = 1'b0;
    exp_dac.push_back(32'hD0);
    chk("t5_space_same", aif.space[7:0], 32'd0);
    chk("t5_no_overrun", aif.status, 32'h0);
    cyc();
    for (int i = 0; i < 16; i++) begin
      pulse_tick();
      cyc();
    end
    chk("t5_drained", exp_dac.size(), 32'd0);
    chk("t5_space_empty", aif.space[7:0], 32'd16);

    // 6: clear with both FIFOs full and a sample pending
    do_clear();
    aif.dac_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_push(32'hE0 + i);
    wr_push(32'hEE);
    for (int i = 0; i < 16; i++) adc_strobe(32'h200 + i);
    pulse_tick();
    pulse_tick();
    chk("t6_status_pre", aif.status, 32'h6);
    chk("t6_space_pre", aif.space, 32'h1001);
    do_clear();
    chk("t6_space", aif.space, 32'h0010);
    chk("t6_status", aif.status, 32'h0);
    chk("t6_dac_valid", aif.dac_valid, 32'h0);
    chk("t6_dac_hold", aif.dac_sample, 32'hE0);

    // reset while a sample is pending
    wr_push(32'hF1);
    pulse_tick();
    chk("rst2_pre_valid", aif.dac_valid, 32'h1);
    #2;
    reset_n = 1'b0;
    aif.ctrl[0] = 1'b1;
    #1;
    chk("rst2_dac_valid", aif.dac_valid, 32'h0);
    chk("rst2_dac_sample", aif.dac_sample, 32'h0);
    chk("rst2_adc_data", aif.adc_data, 32'h0);
    chk("rst2_space", aif.space, 32'h0010);
    chk("rst2_status", aif.status, 32'h0);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("rst2_no_spurious_push", aif.space, 32'h0010);
    chk("final_dac_queue", exp_dac.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
